// File: rtl/mm_pkg.sv
// mm_pkg: instruction encodings, dimension field bounds, FSM states and dmem bases for mm_seq
package mm_pkg;
  localparam logic [2:0] INST_DIM = 3'd0, INST_LDA = 3'd1, INST_LDB = 3'd2, INST_STC = 3'd3, INST_MAC = 3'd4;
  localparam int M_LSB = 0, M_MSB = 10, N_LSB = 11, N_MSB = 21, O_LSB = 22, O_MSB = 31;
  localparam logic [15:0] DIM_BASE = 16'd0, A_BASE = 16'd5120, B_BASE = 16'd10240, C_BASE = 16'd15360;
  typedef enum logic [3:0] {S_IDLE, S_LDDIM, S_CHK, S_LDA, S_LDB, S_MAC, S_STC, S_GAP, S_FIN} state_e;
endpackage

// File: rtl/mm_seq_cnt.sv
// mm_seq_cnt: nested output-block / k-chunk counters with last flags
module mm_seq_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        chunk_inc,
  input  logic        block_inc,
  input  logic [7:0]  chunks,
  input  logic [20:0] mo,
  output logic        last_chunk,
  output logic        last_block
);
  logic [7:0]  chunk_q, chunk_d;
  logic [20:0] block_q, block_d;
  assign last_chunk = chunk_q == chunks - 8'd1;
  assign last_block = block_q == (mo >> 3) - 21'd1;
  always_comb begin
    chunk_d = clr ? '0 : chunk_inc ? (last_chunk ? '0 : chunk_q + 8'd1) : chunk_q;
    block_d = clr ? '0 : block_inc ? block_q + 21'd1 : block_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      chunk_q <= '0;
      block_q <= '0;
    end else begin
      chunk_q <= chunk_d;
      block_q <= block_d;
    end
endmodule

// File: rtl/mm_seq.sv
// mm_seq: matrix-multiply command sequencer (dim load, A/B loads, MAC, C store).
// Define MM_SEQ_PERF_EN to add the busy-cycle counter output cycles.
module mm_seq #(
  parameter logic [2:0] NOP_INST    = 3'd7,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] mem_rdata,
  input  logic         mem_ack,
  input  logic         mac_done,
  output logic [2:0]   inst,
  output logic [255:0] dim,
  output logic         dim_we,
  output logic         busy,
  output logic         done,
`ifdef MM_SEQ_PERF_EN
  output logic [31:0]  cycles,
`endif
  output logic         err
);
  import mm_pkg::*;
  localparam int WW = $clog2(ACK_TIMEOUT + 1);
  state_e state_q, state_d, nxt_q, nxt_d;
  logic [2:0]   ldb_q, ldb_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [255:0] dim_q, dim_d;
  logic         dim_we_q, dim_we_d, err_q, err_d;
  logic         accept, cmd, ack, tmo, chk_bad, last_chunk, last_block;
  logic [10:0]  m, n;
  logic [9:0]   o;
  logic [20:0]  mo;
  assign m       = dim_q[M_MSB:M_LSB];
  assign n       = dim_q[N_MSB:N_LSB];
  assign o       = dim_q[O_MSB:O_LSB];
  assign mo      = 21'(m) * 21'(o);
  assign chk_bad = m == '0 || n == '0 || o == '0 || |n[2:0] || |o[2:0];
  assign accept  = state_q == S_IDLE && start;
  assign cmd     = state_q inside {S_LDDIM, S_LDA, S_LDB, S_MAC, S_STC};
  // only the issuing state listens, and MAC listens to mac_done alone
  assign ack     = cmd && (state_q == S_MAC ? mac_done : mem_ack);
  assign tmo     = cmd && !ack && wait_q == WW'(ACK_TIMEOUT - 1);
  mm_seq_cnt u_cnt (
    .clk(clk), .reset(reset), .clr(accept),
    .chunk_inc(state_q == S_MAC && ack), .block_inc(state_q == S_STC && ack),
    .chunks(n[10:3]), .mo(mo), .last_chunk(last_chunk), .last_block(last_block)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      nxt_q   <= S_IDLE;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
    end
  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    if (tmo) state_d = S_FIN;
    else case (state_q)
      S_IDLE:  if (start) state_d = S_LDDIM;
      S_LDDIM: if (ack) state_d = S_CHK;
      S_CHK:   state_d = chk_bad ? S_FIN : S_LDA;
      S_LDA:   if (ack) begin
        state_d = S_GAP;
        nxt_d   = S_LDB;
      end
      S_LDB:   if (ack) begin
        state_d = S_GAP;
        nxt_d   = &ldb_q ? S_MAC : S_LDB;
      end
      S_MAC:   if (ack) begin
        state_d = S_GAP;
        nxt_d   = last_chunk ? S_STC : S_LDA;
      end
      S_STC:   if (ack) begin
        state_d = last_block ? S_FIN : S_GAP;
        nxt_d   = S_LDA;
      end
      S_GAP:   state_d = nxt_q;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    inst = state_q == S_LDDIM ? INST_DIM :
           state_q == S_LDA   ? INST_LDA :
           state_q == S_LDB   ? INST_LDB :
           state_q == S_MAC   ? INST_MAC :
           state_q == S_STC   ? INST_STC : NOP_INST;
    busy = state_q != S_IDLE && state_q != S_FIN;
    done = state_q == S_FIN;
  end
  always_comb begin
    ldb_d    = state_q == S_LDA ? '0 : (state_q == S_LDB && ack) ? ldb_q + 3'd1 : ldb_q;
    wait_d   = (cmd && !ack) ? wait_q + 1'b1 : '0;
    dim_we_d = state_q == S_LDDIM && ack;
    dim_d    = dim_we_d ? mem_rdata : dim_q;
    err_d    = accept ? 1'b0 : err_q | tmo | (state_q == S_CHK && chk_bad);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ldb_q    <= '0;
      wait_q   <= '0;
      dim_q    <= '0;
      dim_we_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ldb_q    <= ldb_d;
      wait_q   <= wait_d;
      dim_q    <= dim_d;
      dim_we_q <= dim_we_d;
      err_q    <= err_d;
    end
  assign dim    = dim_q;
  assign dim_we = dim_we_q;
  assign err    = err_q;
`ifdef MM_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d;
  assign cyc_d = accept ? '0 : (busy && ~&cyc_q) ? cyc_q + 32'd1 : cyc_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cyc_q <= '0;
    else cyc_q <= cyc_d;
  assign cycles = cyc_q;
`endif
endmodule

// File: tb/tb_mm_seq.sv
// tb_mm_seq: directed self-checking bench for mm_seq with an in-bench ack responder
module tb_mm_seq;
  localparam logic [2:0] NOP = 3'd7;
  logic         clk = 1'b0, reset, start, mem_ack, mac_done;
  logic [255:0] mem_rdata;
  logic [2:0]   inst;
  logic [255:0] dim;
  logic         dim_we, busy, done, err;
`ifdef MM_SEQ_PERF_EN
  logic [31:0]  cycles;
`endif
  int           n_chk = 0, n_fail = 0;
  int           cmds_n, stc_n, done_n, dimwe_n, gap_bad, lda_len;
  logic         err_at_done;
  logic [255:0] sig;
  bit           fin, aborted;

  mm_seq dut (
    .clk(clk), .reset(reset), .start(start), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mac_done(mac_done), .inst(inst), .dim(dim),
    .dim_we(dim_we), .busy(busy), .done(done),
`ifdef MM_SEQ_PERF_EN
    .cycles(cycles),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one job: pulses start, then acks each command one cycle after it appears.
  task automatic job(input logic [31:0] dw, input bit noise, input bit no_lda_ack, input int abort_at);
    int hold = 0, nop_run = 0, cyc = 0;
    logic [2:0] prev = NOP;
    cmds_n = 0; stc_n = 0; done_n = 0; dimwe_n = 0; gap_bad = 0; lda_len = 0;
    err_at_done = 1'bx; sig = '0; fin = 0; aborted = 0;
    mem_rdata = 256'(dw);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    while (!fin && cyc < 3000) begin
      mem_ack = 1'b0; mac_done = 1'b0; start = 1'b0;
      if (done) begin
        done_n++;
        err_at_done = err;
        fin = 1;
      end
      if (dim_we) dimwe_n++;
      if (inst == NOP) begin
        nop_run++;
        hold = 0;
      end else begin
        if (hold == 0 || inst != prev) begin
          if (cmds_n > 0 && nop_run != 1) gap_bad++;
          cmds_n++;
          sig = (sig << 4) | 256'(inst);
          if (inst == 3'd3) stc_n++;
          if (cmds_n == abort_at) aborted = 1;
          hold = 0;
        end
        hold++;
        nop_run = 0;
        if (inst == 3'd1) lda_len++;
        if (hold == 2 && !(no_lda_ack && inst == 3'd1)) begin
          if (inst == 3'd4) mac_done = 1'b1;
          else mem_ack = 1'b1;
        end
        if (noise && inst == 3'd4 && hold == 1) mem_ack = 1'b1;
      end
      if (noise && busy && cyc % 3 == 0) start = 1'b1;
      prev = inst;
      cyc++;
      if (aborted) break;
      @(negedge clk);
    end
    mem_ack = 1'b0; mac_done = 1'b0; start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; mac_done = 1'b0; mem_rdata = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inst", inst, NOP);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dim", dim, 0);
    chk("rst_dim_we", dim_we, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_inst", inst, NOP);

    // m=1 n=8 o=8
    job(32'h0200_4001, 0, 0, 0);
    chk("j1_cmds", cmds_n, 12);
    chk("j1_seq", sig, 48'h0_1222222224_3);
    chk("j1_gap", gap_bad, 0);
    chk("j1_done", done_n, 1);
    chk("j1_err", err_at_done, 0);
    chk("j1_dim", dim, 256'h0200_4001);
    chk("j1_dim_we", dimwe_n, 1);
    chk("j1_idle_busy", busy, 0);

    // m=2 n=16 o=8
    job(32'h0200_8002, 0, 0, 0);
    chk("j2_cmds", cmds_n, 43);
    chk("j2_seq", sig, 172'h0_1222222224_1222222224_3_1222222224_1222222224_3);
    chk("j2_stc", stc_n, 2);
    chk("j2_gap", gap_bad, 0);
    chk("j2_done", done_n, 1);
    chk("j2_err", err_at_done, 0);

    // zero dimension word
    job(32'h0, 0, 0, 0);
    chk("j3_cmds", cmds_n, 1);
    chk("j3_done", done_n, 1);
    chk("j3_err", err_at_done, 1);
    chk("j3_err_sticky", err, 1);

    // n=12 not a multiple of 8
    job(32'h0200_6001, 0, 0, 0);
    chk("j4_cmds", cmds_n, 1);
    chk("j4_done", done_n, 1);
    chk("j4_err", err_at_done, 1);

    // stray starts and a stray mem_ack during MAC
    job(32'h0200_4001, 1, 0, 0);
    chk("j5_cmds", cmds_n, 12);
    chk("j5_seq", sig, 48'h0_1222222224_3);
    chk("j5_gap", gap_bad, 0);
    chk("j5_done", done_n, 1);
    chk("j5_err", err_at_done, 0);

    // mem_ack withheld on LDA
    job(32'h0200_4001, 0, 1, 0);
    chk("j6_cmds", cmds_n, 2);
    chk("j6_seq", sig, 8'h01);
    chk("j6_lda_len", lda_len, 255);
    chk("j6_done", done_n, 1);
    chk("j6_err", err_at_done, 1);
    chk("j6_idle_busy", busy, 0);
    chk("j6_idle_inst", inst, NOP);

    // reset during the 3rd LDB
    job(32'h0200_4001, 0, 0, 5);
    chk("j7_aborted", aborted, 1);
    chk("j7_at_ldb", inst, 3'd2);
    #2 reset = 1'b0;
    #1;
    chk("j7_rst_inst", inst, NOP);
    chk("j7_rst_busy", busy, 0);
    chk("j7_rst_done", done, 0);
    chk("j7_rst_dim", dim, 0);
    chk("j7_rst_dim_we", dim_we, 0);
    chk("j7_rst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    done_n = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("j7_no_done", done_n, 0);
    chk("j7_idle_inst", inst, NOP);
    job(32'h0200_4001, 0, 0, 0);
    chk("j8_cmds", cmds_n, 12);
    chk("j8_seq", sig, 48'h0_1222222224_3);
    chk("j8_done", done_n, 1);
    chk("j8_err", err_at_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
